// File: rtl/conv1d_pkg.sv
// Shared types and sizing helpers for the parametrised 1-D convolution engine.
package conv1d_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE,
    KER_REQ,
    KER_WAIT,
    IN_REQ,
    IN_WAIT,
    WR,
    FINISH
  } conv_state_t;

  function automatic int clog2_int(input int value);
    int bits;
    bits = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << bits) < value) bits++;
    end
    return bits;
  endfunction

  // Wide enough that a full kernel of worst-case products can never wrap.
  function automatic int acc_width(input int dataW, input int kerLen);
    return 2 * dataW + clog2_int(kerLen);
  endfunction

endpackage

// File: rtl/conv1d_mac.sv
// Multiply-accumulate stage: owns the wide accumulator and the saturate/ReLU output path.
module conv1d_mac
  import conv1d_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int KER_LEN = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ker,
  input  logic [DATA_W-1:0] data,
  input  logic              clear,
  input  logic              enable,
  input  logic              relu,
  output logic [DATA_W-1:0] result,
  output logic              sat
);

  localparam int ACC_W = acc_width(DATA_W, KER_LEN);

  logic signed [2*DATA_W-1:0] w_kerExt;
  logic signed [2*DATA_W-1:0] w_dataExt;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prodExt;
  logic signed [ACC_W-1:0]    r_acc;
  logic [ACC_W-DATA_W:0]      w_upper;
  logic [DATA_W-1:0]          w_satVal;

  assign w_kerExt  = (2*DATA_W)'($signed(ker));
  assign w_dataExt = (2*DATA_W)'($signed(data));
  assign w_prod    = w_kerExt * w_dataExt;
  assign w_prodExt = ACC_W'(w_prod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (clear) begin
      r_acc <= '0;
    end else if (enable) begin
      r_acc <= r_acc + w_prodExt;
    end
  end

  // The value fits DATA_W only when every bit above the result sign bit copies it.
  assign w_upper = r_acc[ACC_W-1:DATA_W-1];
  assign sat     = !((&w_upper) || (~|w_upper));

  always_comb begin
    w_satVal = r_acc[DATA_W-1:0];
    if (sat) begin
      w_satVal = r_acc[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
    result = (relu && w_satVal[DATA_W-1]) ? '0 : w_satVal;
  end

endmodule

// File: rtl/conv1d_engine.sv
// Memory-driven 1-D convolution: loads the kernel once, then streams inputs and
// writes each post-processed output through a grant-based single-port handshake.
module conv1d_engine
  import conv1d_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                KER_LEN  = 5,
  parameter int                OUT_LEN  = 128,
  parameter int                STRIDE   = 1,
  parameter logic [ADDR_W-1:0] KER_BASE = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] IN_BASE  = 32'h0000_0100,
  parameter logic [ADDR_W-1:0] OUT_BASE = 32'h0000_1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              relu_en,
  output logic              busy,
  output logic              done,
  output logic              sat_flag,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int K_W = (KER_LEN > 1) ? $clog2(KER_LEN) : 1;
  localparam int O_W = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
  localparam logic [K_W-1:0]    K_LAST  = K_W'(KER_LEN - 1);
  localparam logic [O_W-1:0]    O_LAST  = O_W'(OUT_LEN - 1);
  localparam logic [ADDR_W-1:0] W_BYTES = ADDR_W'(WORD_BYTES);
  localparam logic [ADDR_W-1:0] IN_STEP = ADDR_W'(STRIDE * WORD_BYTES);

  conv_state_t       r_state;
  conv_state_t       w_nextState;
  logic [K_W-1:0]    r_k;
  logic [O_W-1:0]    r_o;
  logic [ADDR_W-1:0] r_inOff;
  logic              r_relu;
  logic              r_sat;
  logic [DATA_W-1:0] r_ker [KER_LEN];

  logic              w_kLast;
  logic              w_oLast;
  logic [DATA_W-1:0] w_kerTap;
  logic              w_macClear;
  logic              w_macEnable;
  logic [DATA_W-1:0] w_macResult;
  logic              w_macSat;

  assign w_kLast     = (r_k == K_LAST);
  assign w_oLast     = (r_o == O_LAST);
  assign w_kerTap    = r_ker[r_k];
  assign w_macClear  = (r_state == IN_REQ) && (r_k == '0);
  assign w_macEnable = (r_state == IN_WAIT);
  assign sat_flag    = r_sat;

  conv1d_mac #(
    .DATA_W (DATA_W),
    .KER_LEN(KER_LEN)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .ker   (w_kerTap),
    .data  (mem_rdata),
    .clear (w_macClear),
    .enable(w_macEnable),
    .relu  (r_relu),
    .result(w_macResult),
    .sat   (w_macSat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Outputs depend on state and registered indices only, never on mem_gnt.
  always_comb begin
    w_nextState = r_state;
    busy        = 1'b1;
    done        = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_nextState = KER_REQ;
      end
      KER_REQ: begin
        mem_req  = 1'b1;
        mem_addr = KER_BASE + ADDR_W'(r_k) * W_BYTES;
        if (mem_gnt) w_nextState = KER_WAIT;
      end
      KER_WAIT: begin
        w_nextState = w_kLast ? IN_REQ : KER_REQ;
      end
      IN_REQ: begin
        mem_req  = 1'b1;
        mem_addr = IN_BASE + r_inOff + ADDR_W'(r_k) * W_BYTES;
        if (mem_gnt) w_nextState = IN_WAIT;
      end
      IN_WAIT: begin
        w_nextState = w_kLast ? WR : IN_REQ;
      end
      WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = OUT_BASE + ADDR_W'(r_o) * W_BYTES;
        mem_wdata = w_macResult;
        if (mem_gnt) w_nextState = w_oLast ? FINISH : IN_REQ;
      end
      FINISH: begin
        done        = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
    if (abort && (r_state != IDLE)) w_nextState = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k     <= '0;
      r_o     <= '0;
      r_inOff <= '0;
      r_relu  <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_k     <= '0;
            r_o     <= '0;
            r_inOff <= '0;
            r_relu  <= relu_en;
            r_sat   <= 1'b0;
          end
        end
        KER_WAIT, IN_WAIT: begin
          r_k <= w_kLast ? '0 : r_k + K_W'(1);
        end
        WR: begin
          if (mem_gnt) begin
            r_o     <= r_o + O_W'(1);
            r_inOff <= r_inOff + IN_STEP;
            if (w_macSat) r_sat <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Kernel taps live in a plain register file, rewritten on every run.
  always_ff @(posedge clk) begin
    if (r_state == KER_WAIT) r_ker[r_k] <= mem_rdata;
  end

endmodule
